// File: rtl/hpdcache_lfsr_rand_idx.sv
// Galois LFSR with seed load/step plus rejection-sampling index draw; req->rsp 2..MAX_RETRY+2 cycles,
// response held until rsp_ready_i. Define HPDCACHE_LFSR_ZERO_GUARD_EN to replace a zero next state by all-ones.
module hpdcache_lfsr_rand_idx #(
  parameter int WIDTH      = 16,
  parameter int POLY       = 0,
  parameter int STEPS      = 1,
  parameter int NUM_VALUES = 8,
  parameter int MAX_RETRY  = 3,
  localparam int IDX_W     = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] val_o,
  input  logic             req_i,
  output logic             req_ready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [IDX_W-1:0] rsp_idx_o,
  output logic             rsp_fallback_o,
  output logic             lockup_o
);

  localparam logic [15:0] TABLE_MASK =
      (WIDTH == 8)  ? 16'h00E1 : (WIDTH == 9)  ? 16'h01EA : (WIDTH == 10) ? 16'h02E3 :
      (WIDTH == 11) ? 16'h04E3 : (WIDTH == 12) ? 16'h0AE2 : (WIDTH == 13) ? 16'h10E3 :
      (WIDTH == 14) ? 16'h20EA : (WIDTH == 15) ? 16'h41E2 : 16'h81EE;
  localparam logic [WIDTH-1:0] MASK = (POLY != 0) ? WIDTH'(POLY) : TABLE_MASK[WIDTH-1:0];
  localparam logic [IDX_W:0]   NV   = (IDX_W + 1)'(NUM_VALUES);
  localparam int               RW   = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RETRY_LAST = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, DRAW, RESP} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_n, lfsr_d;
  logic [RW-1:0]    retry_q;
  logic [IDX_W-1:0] idx_q, cand, cand_wrap;
  logic             fb_q, rdy_q, vld_q, cand_ok;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? MASK : '0);
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_adv(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < STEPS; i++) r = lfsr_step(r);
    return r;
  endfunction

  // Seed beats the draw engine's own advance, which beats an external shift.
  always_comb begin
    lfsr_n = lfsr_q;
    if (seed_load_i) lfsr_n = seed_i;
    else if (state_q == DRAW || (state_q == IDLE && shift_i)) lfsr_n = lfsr_adv(lfsr_q);
  end

`ifdef HPDCACHE_LFSR_ZERO_GUARD_EN
  logic zero_hit, lockup_q;
  // With the guard active the held state is never zero, so a zero here is always a fresh load/step.
  assign zero_hit = (lfsr_n == '0);
  assign lfsr_d   = zero_hit ? '1 : lfsr_n;
  assign lockup_o = lockup_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lockup_q <= 1'b0;
    else         lockup_q <= zero_hit;
  end
`else
  assign lfsr_d   = lfsr_n;
  assign lockup_o = 1'b0;
`endif

  assign cand      = lfsr_q[IDX_W-1:0];
  assign cand_ok   = {1'b0, cand} < NV;
  assign cand_wrap = IDX_W'({1'b0, cand} - NV);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q  <= '1;
      state_q <= IDLE;
      retry_q <= '0;
      idx_q   <= '0;
      fb_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: if (req_i) begin
          state_q <= DRAW;
          retry_q <= '0;
          rdy_q   <= 1'b0;
        end
        DRAW: if (cand_ok) begin
          idx_q   <= cand;
          fb_q    <= 1'b0;
          vld_q   <= 1'b1;
          state_q <= RESP;
        end else if (retry_q == RETRY_LAST) begin
          idx_q   <= cand_wrap;
          fb_q    <= 1'b1;
          vld_q   <= 1'b1;
          state_q <= RESP;
        end else begin
          retry_q <= retry_q + 1'b1;
        end
        RESP: if (rsp_ready_i) begin
          vld_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign val_o          = lfsr_q;
  assign req_ready_o    = rdy_q;
  assign rsp_valid_o    = vld_q;
  assign rsp_idx_o      = idx_q;
  assign rsp_fallback_o = fb_q;

endmodule

// File: tb/tb_hpdcache_lfsr_rand_idx.sv
// Bench for hpdcache_lfsr_rand_idx: three 8-bit configurations, vector table, corner sequences, random vs model.
module tb_hpdcache_lfsr_rand_idx;

  logic       clk, rst_n;
  logic       shift[3], seed_load[3], req[3], rsp_ready[3];
  logic       req_ready[3], rsp_valid[3], fb[3], lock[3];
  logic [7:0] seed[3], val[3];
  logic [2:0] idx[3];
  logic [7:0] ms[3];
  int         n_checks, n_errors;

  // Instance 0: NUM_VALUES=5, MAX_RETRY=8; 1: NUM_VALUES=8, STEPS=2; 2: NUM_VALUES=5, MAX_RETRY=2.
  hpdcache_lfsr_rand_idx #(.WIDTH(8), .POLY(0), .STEPS(1), .NUM_VALUES(5), .MAX_RETRY(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift[0]), .seed_load_i(seed_load[0]), .seed_i(seed[0]),
    .val_o(val[0]), .req_i(req[0]), .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]),
    .rsp_ready_i(rsp_ready[0]), .rsp_idx_o(idx[0]), .rsp_fallback_o(fb[0]), .lockup_o(lock[0]));
  hpdcache_lfsr_rand_idx #(.WIDTH(8), .POLY(0), .STEPS(2), .NUM_VALUES(8), .MAX_RETRY(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift[1]), .seed_load_i(seed_load[1]), .seed_i(seed[1]),
    .val_o(val[1]), .req_i(req[1]), .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]),
    .rsp_ready_i(rsp_ready[1]), .rsp_idx_o(idx[1]), .rsp_fallback_o(fb[1]), .lockup_o(lock[1]));
  hpdcache_lfsr_rand_idx #(.WIDTH(8), .POLY(0), .STEPS(1), .NUM_VALUES(5), .MAX_RETRY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift[2]), .seed_load_i(seed_load[2]), .seed_i(seed[2]),
    .val_o(val[2]), .req_i(req[2]), .req_ready_o(req_ready[2]), .rsp_valid_o(rsp_valid[2]),
    .rsp_ready_i(rsp_ready[2]), .rsp_idx_o(idx[2]), .rsp_fallback_o(fb[2]), .lockup_o(lock[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    logic [7:0] seed;
    int         idx;
    bit         fb;
    int         lat;
    logic [7:0] fin;
    int         hold;
  } vec_t;
  vec_t vecs[8];

  function automatic int nv_of(input int i);
    return (i == 1) ? 8 : 5;
  endfunction
  function automatic int mr_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 3 : 2);
  endfunction
  function automatic int st_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Reference: the LFSR as a number, halved and xored with the tap mask when odd.
  function automatic logic [7:0] m_step(input logic [7:0] s);
    return (s / 2) ^ ((s % 2 == 1) ? 8'hE1 : 8'h00);
  endfunction
  function automatic logic [7:0] m_adv(input logic [7:0] s, input int n);
    logic [7:0] r;
    r = s;
    for (int k = 0; k < n; k++) r = m_step(r);
    return r;
  endfunction
  function automatic logic [7:0] m_seed(input logic [7:0] v);
`ifdef HPDCACHE_LFSR_ZERO_GUARD_EN
    return (v == 8'h00) ? 8'hFF : v;
`else
    return v;
`endif
  endfunction

  task automatic m_draw(input int i, input logic [7:0] s0, output int e_idx, output bit e_fb,
                        output int e_lat, output logic [7:0] e_fin);
    logic [7:0] s;
    int c, tries;
    s = s0; tries = 0; e_idx = 0; e_fb = 1'b0;
    for (int t = 0; t <= mr_of(i); t++) begin
      c = int'(s % 8);
      s = m_adv(s, st_of(i));
      tries = t + 1;
      if (c < nv_of(i)) begin
        e_idx = c; e_fb = 1'b0;
        break;
      end else if (t == mr_of(i)) begin
        e_idx = c - nv_of(i); e_fb = 1'b1;
      end
    end
    e_lat = tries + 1;
    e_fin = s;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input int i, input logic [7:0] v);
    seed[i] = v; seed_load[i] = 1'b1;
    step();
    seed_load[i] = 1'b0;
  endtask

  task automatic run_draw(input int i, input int e_idx, input bit e_fb, input int e_lat,
                          input logic [7:0] e_val, input int hold);
    int n;
    check("req_ready before draw", int'(req_ready[i]), 1);
    req[i] = 1'b1;
    step();
    req[i] = 1'b0;
    n = 1;
    while (!rsp_valid[i] && n < 40) begin
      step();
      n++;
    end
    check("draw latency", n, e_lat);
    check("rsp_idx", int'(idx[i]), e_idx);
    check("rsp_fallback", int'(fb[i]), int'(e_fb));
    check("val after draw", int'(val[i]), int'(e_val));
    if (hold > 0) begin
      repeat (hold) step();
      check("held rsp_valid", int'(rsp_valid[i]), 1);
      check("held rsp_idx", int'(idx[i]), e_idx);
      check("held req_ready", int'(req_ready[i]), 0);
      check("held val frozen", int'(val[i]), int'(e_val));
    end
    rsp_ready[i] = 1'b1;
    step();
    rsp_ready[i] = 1'b0;
    check("rsp_valid after accept", int'(rsp_valid[i]), 0);
    check("req_ready after accept", int'(req_ready[i]), 1);
  endtask

  initial begin
    int         e_idx, e_lat, n;
    bit         e_fb;
    logic [7:0] e_fin, v;

    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift[i] = 1'b0; seed_load[i] = 1'b0; seed[i] = 8'h00; req[i] = 1'b0; rsp_ready[i] = 1'b0;
    end
    vecs[0] = '{0, 8'hFF, 3, 1'b0, 6, 8'hD0, 10};
    vecs[1] = '{2, 8'hFF, 2, 1'b1, 4, 8'hC6, 0};
    vecs[2] = '{1, 8'hFF, 7, 1'b0, 2, 8'h4F, 2};
    vecs[3] = '{0, 8'h63, 3, 1'b0, 2, 8'hD0, 0};
    vecs[4] = '{0, 8'h10, 0, 1'b0, 2, 8'h08, 0};
    vecs[5] = '{2, 8'h0E, 2, 1'b0, 4, 8'h71, 1};
    vecs[6] = '{2, 8'h05, 3, 1'b0, 3, 8'h90, 0};
    vecs[7] = '{1, 8'h03, 3, 1'b0, 2, 8'h70, 0};

    #12;
    check("reset val", int'(val[0]), 8'hFF);
    check("reset req_ready", int'(req_ready[0]), 1);
    check("reset rsp_valid", int'(rsp_valid[0]), 0);
    check("reset rsp_idx", int'(idx[0]), 0);
    check("reset fallback", int'(fb[0]), 0);
    check("reset lockup", int'(lock[0]), 0);
    rst_n = 1'b1;
    step();

    shift[0] = 1'b1; shift[1] = 1'b1;
    step();
    shift[1] = 1'b0;
    check("shift1 steps1", int'(val[0]), 8'h9E);
    check("shift1 steps2", int'(val[1]), 8'h4F);
    step();
    shift[0] = 1'b0;
    check("shift2 steps1", int'(val[0]), 8'h4F);

    foreach (vecs[k]) begin
      load_seed(vecs[k].inst, vecs[k].seed);
      check("seed loaded", int'(val[vecs[k].inst]), int'(vecs[k].seed));
      run_draw(vecs[k].inst, vecs[k].idx, vecs[k].fb, vecs[k].lat, vecs[k].fin, vecs[k].hold);
    end

    // Seed load mid-draw keeps the retry count; shift/req/rsp_ready are ignored while busy.
    load_seed(0, 8'hFF);
    req[0] = 1'b1;
    step();
    seed[0] = 8'h63; seed_load[0] = 1'b1; shift[0] = 1'b1; rsp_ready[0] = 1'b1;
    step();
    seed_load[0] = 1'b0; shift[0] = 1'b0; rsp_ready[0] = 1'b0;
    check("seed over draw advance", int'(val[0]), 8'h63);
    n = 2;
    while (!rsp_valid[0] && n < 40) begin
      step();
      n++;
    end
    req[0] = 1'b0;
    check("mid-draw seed latency", n, 3);
    check("mid-draw seed idx", int'(idx[0]), 3);
    check("mid-draw seed val", int'(val[0]), 8'hD0);
    req[0] = 1'b1; shift[0] = 1'b1;
    step(); step();
    req[0] = 1'b0; shift[0] = 1'b0;
    check("req/shift ignored in resp", int'(val[0]), 8'hD0);
    check("resp still valid", int'(rsp_valid[0]), 1);
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    check("no bypass after accept", int'(req_ready[0]), 1);
    step();
    check("req not queued", int'(req_ready[0]), 1);

    load_seed(0, 8'h00);
`ifdef HPDCACHE_LFSR_ZERO_GUARD_EN
    check("zero seed recovered", int'(val[0]), 8'hFF);
    check("lockup pulse", int'(lock[0]), 1);
    step();
    check("lockup one cycle", int'(lock[0]), 0);
`else
    check("zero seed kept", int'(val[0]), 8'h00);
    check("lockup tied low", int'(lock[0]), 0);
`endif
    m_draw(0, m_seed(8'h00), e_idx, e_fb, e_lat, e_fin);
    run_draw(0, e_idx, e_fb, e_lat, e_fin, 0);

    for (int i = 0; i < 3; i++) begin
      load_seed(i, 8'hA5);
      ms[i] = 8'hA5;
      for (int it = 0; it < 60; it++) begin
        case ($urandom_range(0, 3))
          1: begin
            n = int'($urandom_range(1, 3));
            shift[i] = 1'b1;
            repeat (n) step();
            shift[i] = 1'b0;
            ms[i] = m_adv(ms[i], n * st_of(i));
          end
          2: begin
            v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            load_seed(i, v);
            ms[i] = m_seed(v);
          end
          default: ;
        endcase
        check("random val before draw", int'(val[i]), int'(ms[i]));
        m_draw(i, ms[i], e_idx, e_fb, e_lat, e_fin);
        run_draw(i, e_idx, e_fb, e_lat, e_fin, int'($urandom_range(0, 2)));
        ms[i] = e_fin;
      end
    end

    load_seed(0, 8'h3C);
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset val", int'(val[0]), 8'hFF);
    check("async reset req_ready", int'(req_ready[0]), 1);
    check("async reset rsp_valid", int'(rsp_valid[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
